fir_channel_arbiter: RTL

//  Time-shares one FIR Compiler II instance between two audio channels (ch0/ch1).

---
 rtl/fir_channel_arbiter_if.sv | 41 ++++
 rtl/fir_channel_arbiter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/fir_channel_arbiter_if.sv
// Handshake and data bus between the two audio channels, the shared FIR and
// the arbiter. The arbiter takes the slave side; the environment takes master.
interface fir_channel_arbiter_if #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 4
);
  logic              flush;
  logic [DATA_W-1:0] ch0_sample_in;
  logic              ch0_valid_in;
  logic              ch0_ready_out;
  logic [DATA_W-1:0] ch1_sample_in;
  logic              ch1_valid_in;
  logic              ch1_ready_out;
  logic [DATA_W-1:0] fir_sink_data;
  logic              fir_sink_valid;
  logic              fir_sink_ready;
  logic [DATA_W-1:0] fir_source_data;
  logic              fir_source_valid;
  logic [DATA_W-1:0] ch0_sample_out;
  logic              ch0_valid_out;
  logic [DATA_W-1:0] ch1_sample_out;
  logic              ch1_valid_out;
  logic [CNT_W-1:0]  inflight;
  logic              orphan_err;

  modport slave (
    input  flush, ch0_sample_in, ch0_valid_in, ch1_sample_in, ch1_valid_in,
           fir_sink_ready, fir_source_data, fir_source_valid,
    output ch0_ready_out, ch1_ready_out, fir_sink_data, fir_sink_valid,
           ch0_sample_out, ch0_valid_out, ch1_sample_out, ch1_valid_out,
           inflight, orphan_err
  );

  modport master (
    output flush, ch0_sample_in, ch0_valid_in, ch1_sample_in, ch1_valid_in,
           fir_sink_ready, fir_source_data, fir_source_valid,
    input  ch0_ready_out, ch1_ready_out, fir_sink_data, fir_sink_valid,
           ch0_sample_out, ch0_valid_out, ch1_sample_out, ch1_valid_out,
           inflight, orphan_err
  );
endinterface

// File: rtl/fir_channel_arbiter.sv
// Time-shares one FIR between two audio channels. Each channel has a one-entry
// hold; round-robin issue feeds the FIR sink and a tag FIFO remembers which
// channel each in-flight sample belongs to so in-order results route back.
module fir_channel_arbiter #(
  parameter int DATA_W       = 16,
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fir_channel_arbiter_if.slave  bus
);
  localparam int AW = $clog2(MAX_INFLIGHT);

  logic [1:0][DATA_W-1:0]   hold_q, hold_d;
  logic [1:0]               full_q, full_d;
  logic                     last_grant_q, last_grant_d;
  logic [MAX_INFLIGHT-1:0]  tag_q, tag_d;
  logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [DATA_W-1:0]        sink_data_q, sink_data_d;
  logic                     sink_valid_q, sink_valid_d;
  logic [1:0][DATA_W-1:0]   out_q, out_d;
  logic [1:0]               vout_q, vout_d;
  logic                     orphan_q, orphan_d;

  logic [1:0][DATA_W-1:0]   din;
  logic [1:0]               vin;
  logic                     issue, grant, pop, head_tag;

  assign din = {bus.ch1_sample_in, bus.ch0_sample_in};
  assign vin = {bus.ch1_valid_in, bus.ch0_valid_in};

  // Next-state: accept into holds, arbitrate one issue, pop tags on FIR return.
  always_comb begin
    hold_d       = hold_q;
    full_d       = full_q;
    last_grant_d = last_grant_q;
    tag_d        = tag_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    sink_data_d  = sink_data_q;
    out_d        = out_q;
    orphan_d     = orphan_q;

    // Inflight count equals tag FIFO occupancy, so it doubles as the credit.
    issue    = bus.fir_sink_ready && (cnt_q < CNT_W'(MAX_INFLIGHT)) && (|full_q);
    // Both full: alternate away from the last winner; otherwise take whichever is full.
    grant    = (&full_q) ? ~last_grant_q : full_q[1];
    pop      = bus.fir_source_valid && (cnt_q != '0);
    head_tag = tag_q[rptr_q];

    // A hold only loads while empty, so an issue and a load never hit the same hold.
    for (int c = 0; c < 2; c++) begin
      if (!full_q[c] && vin[c]) begin
        hold_d[c] = din[c];
        full_d[c] = 1'b1;
      end
    end

    sink_valid_d = issue;
    if (issue) begin
      full_d[grant] = 1'b0;
      sink_data_d   = hold_q[grant];
      tag_d[wptr_q] = grant;
      wptr_d        = wptr_q + AW'(1);
      last_grant_d  = grant;
    end

    vout_d = 2'b00;
    if (pop) begin
      out_d[head_tag]  = bus.fir_source_data;
      vout_d[head_tag] = 1'b1;
      rptr_d           = rptr_q + AW'(1);
    end

    // Results with no pending tag are dropped and only flagged.
    if (bus.fir_source_valid && (cnt_q == '0)) orphan_d = 1'b1;

    case ({issue, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // State registers; flush clears the same state as reset.
  always_ff @(posedge clk) begin
    if (!reset_n || bus.flush) begin
      hold_q       <= '0;
      full_q       <= '0;
      last_grant_q <= 1'b1;
      tag_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      sink_data_q  <= '0;
      sink_valid_q <= 1'b0;
      out_q        <= '0;
      vout_q       <= '0;
      orphan_q     <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      full_q       <= full_d;
      last_grant_q <= last_grant_d;
      tag_q        <= tag_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      sink_data_q  <= sink_data_d;
      sink_valid_q <= sink_valid_d;
      out_q        <= out_d;
      vout_q       <= vout_d;
      orphan_q     <= orphan_d;
    end
  end

  assign bus.ch0_ready_out  = ~full_q[0];
  assign bus.ch1_ready_out  = ~full_q[1];
  assign bus.fir_sink_data  = sink_data_q;
  assign bus.fir_sink_valid = sink_valid_q;
  assign bus.ch0_sample_out = out_q[0];
  assign bus.ch0_valid_out  = vout_q[0];
  assign bus.ch1_sample_out = out_q[1];
  assign bus.ch1_valid_out  = vout_q[1];
  assign bus.inflight       = cnt_q;
  assign bus.orphan_err     = orphan_q;
endmodule
